// File: rtl/mem_stage_pkg.sv
`default_nettype none
//==============================================================
// Module : mem_stage_pkg
// Shared types and defaults for the MEM pipeline stage.
// Rev    : 1.0
//==============================================================
package mem_stage_pkg;

   localparam int DEFAULT_DEPTH   = 256;
   localparam int DEFAULT_MEM_LAT = 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } memState_e;

   typedef enum logic [1:0] {
      PC_SEL_MEMJ = 2'd0,
      PC_SEL_REGJ = 2'd1,
      PC_SEL_BR   = 2'd2
   } pcSel_e;

endpackage
`default_nettype wire

// File: rtl/mem_stage_data_ram.sv
`default_nettype none
//==============================================================
// Module : mem_stage_data_ram
// Single-port word RAM, posedge write, asynchronous read.
// Rev    : 1.0
//==============================================================
module mem_stage_data_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[addr] <= wdata;
      end
   end

   assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
//==============================================================
// Module : mem_stage
// MEM stage: data memory access FSM, branch resolution, MEM/WB
// register. Define MEM_STATS_EN for retired-event counters.
// Rev    : 1.0
//==============================================================
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regWriteMEM,
   input  logic        memToRegMEM,
   input  logic        JumpMEM,
   input  logic        JumpMemMEM,
   input  logic        MemWriteMEM,
   input  logic        MemReadMEM,
   input  logic        BranchNegMEM,
   input  logic        BranchZeroMEM,
   input  logic        zeroMEM,
   input  logic        negMEM,
   input  logic [31:0] ALUSrc1MEM,
   input  logic [31:0] AluResultsMEM,
   input  logic [31:0] rtMEM,
   input  logic [5:0]  rdMEM,
   output logic        stall,
   output logic        pcSrc,
   output logic        flush,
   output logic [31:0] pcTarget,
   output logic        regWriteWB,
   output logic        memToRegWB,
   output logic [31:0] memDataWB,
   output logic [31:0] aluResultWB,
   output logic [5:0]  rdWB,
   output logic [31:0] loadCount,
   output logic [31:0] storeCount,
   output logic [31:0] takenCount
);

   localparam int             AW      = $clog2(DEPTH);
   localparam int             CW      = $clog2(MEM_LAT + 1);
   localparam logic [CW-1:0]  c_LAST  = CW'(MEM_LAT - 1);
   localparam logic           c_MULTI = (MEM_LAT > 1);

   memState_e      r_state;
   logic [CW-1:0]  r_cnt;
   logic           w_access;
   logic           w_stall;
   logic           w_complete;
   logic           w_taken;
   logic           w_we;
   logic [31:0]    w_rdata;
   pcSel_e         w_pcSel;

   assign w_access = MemReadMEM | MemWriteMEM | JumpMemMEM;

   // The counter only climbs to c_LAST, so equality marks the completing cycle.
   always_comb begin
      w_stall = 1'b0;
      if (r_state == IDLE) begin
         w_stall = w_access & c_MULTI;
      end else begin
         w_stall = (r_cnt != c_LAST);
      end
      w_stall = w_stall & ~rst;
   end

   assign w_complete = ~w_stall & ~rst;
   assign w_we       = MemWriteMEM & w_complete;
   assign stall      = w_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_access && c_MULTI) begin
                  r_state <= WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            WAIT: begin
               if (r_cnt == c_LAST) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   mem_stage_data_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_dataRam (
      .clk   (clk),
      .we    (w_we),
      .addr  (AluResultsMEM[AW-1:0]),
      .wdata (rtMEM),
      .rdata (w_rdata)
   );

   assign w_taken = JumpMEM | JumpMemMEM | (BranchZeroMEM & zeroMEM) | (BranchNegMEM & negMEM);
   assign pcSrc   = w_taken & w_complete;
   assign flush   = pcSrc;

   always_comb begin
      w_pcSel = PC_SEL_BR;
      if (JumpMemMEM) begin
         w_pcSel = PC_SEL_MEMJ;
      end else if (JumpMEM) begin
         w_pcSel = PC_SEL_REGJ;
      end
   end

   always_comb begin
      case (w_pcSel)
         PC_SEL_MEMJ: pcTarget = w_rdata;
         PC_SEL_REGJ: pcTarget = ALUSrc1MEM;
         default:     pcTarget = AluResultsMEM;
      endcase
   end

   // Read data is sampled before the same-edge write lands, so a combined
   // read/write returns the pre-write word.
   always_ff @(posedge clk) begin
      if (rst || w_stall) begin
         regWriteWB  <= 1'b0;
         memToRegWB  <= 1'b0;
         memDataWB   <= '0;
         aluResultWB <= '0;
         rdWB        <= '0;
      end else begin
         regWriteWB  <= regWriteMEM;
         memToRegWB  <= memToRegMEM;
         memDataWB   <= w_rdata;
         aluResultWB <= AluResultsMEM;
         rdWB        <= rdMEM;
      end
   end

`ifdef MEM_STATS_EN
   logic [31:0] r_loadCount;
   logic [31:0] r_storeCount;
   logic [31:0] r_takenCount;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_loadCount  <= '0;
         r_storeCount <= '0;
         r_takenCount <= '0;
      end else begin
         if (MemReadMEM && w_complete) begin
            r_loadCount <= r_loadCount + 32'd1;
         end
         if (MemWriteMEM && w_complete) begin
            r_storeCount <= r_storeCount + 32'd1;
         end
         if (pcSrc) begin
            r_takenCount <= r_takenCount + 32'd1;
         end
      end
   end

   assign loadCount  = r_loadCount;
   assign storeCount = r_storeCount;
   assign takenCount = r_takenCount;
`else
   assign loadCount  = '0;
   assign storeCount = '0;
   assign takenCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
//==============================================================
// Module : tb_mem_stage
// Scoreboard bench for mem_stage at MEM_LAT = 1, 2 and 3.
// Rev    : 1.0
//==============================================================
module tb_mem_stage;

   typedef struct packed {
      logic        regWrite;
      logic        memToReg;
      logic        jump;
      logic        jumpMem;
      logic        memWrite;
      logic        memRead;
      logic        brNeg;
      logic        brZero;
      logic        zero;
      logic        neg;
      logic [31:0] src1;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [5:0]  rd;
   } ins_t;

   typedef struct {
      logic        regWrite;
      logic        memToReg;
      logic [31:0] data;
      logic [31:0] alu;
      logic [5:0]  rd;
      bit          chkData;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   ins_t        ins    [3];
   logic        stallO [3];
   logic        pcSrcO [3];
   logic        flushO [3];
   logic        rwO    [3];
   logic        mtrO   [3];
   logic [31:0] tgtO   [3];
   logic [31:0] dataO  [3];
   logic [31:0] aluO   [3];
   logic [5:0]  rdO    [3];
   logic [31:0] lcO    [3];
   logic [31:0] scO    [3];
   logic [31:0] tcO    [3];

   logic [31:0] model [3][256];
   wb_t         sb[$];
   int          vectors     = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         mem_stage #(.DEPTH(256), .MEM_LAT(g + 1)) u_dut (
            .clk           (clk),
            .rst           (rst),
            .regWriteMEM   (ins[g].regWrite),
            .memToRegMEM   (ins[g].memToReg),
            .JumpMEM       (ins[g].jump),
            .JumpMemMEM    (ins[g].jumpMem),
            .MemWriteMEM   (ins[g].memWrite),
            .MemReadMEM    (ins[g].memRead),
            .BranchNegMEM  (ins[g].brNeg),
            .BranchZeroMEM (ins[g].brZero),
            .zeroMEM       (ins[g].zero),
            .negMEM        (ins[g].neg),
            .ALUSrc1MEM    (ins[g].src1),
            .AluResultsMEM (ins[g].alu),
            .rtMEM         (ins[g].rt),
            .rdMEM         (ins[g].rd),
            .stall         (stallO[g]),
            .pcSrc         (pcSrcO[g]),
            .flush         (flushO[g]),
            .pcTarget      (tgtO[g]),
            .regWriteWB    (rwO[g]),
            .memToRegWB    (mtrO[g]),
            .memDataWB     (dataO[g]),
            .aluResultWB   (aluO[g]),
            .rdWB          (rdO[g]),
            .loadCount     (lcO[g]),
            .storeCount    (scO[g]),
            .takenCount    (tcO[g])
         );
      end
   endgenerate

   function automatic ins_t ld(input logic [31:0] a, input logic [5:0] r);
      ins_t i = '0;
      i.memRead  = 1'b1;
      i.regWrite = 1'b1;
      i.memToReg = 1'b1;
      i.alu      = a;
      i.rd       = r;
      return i;
   endfunction

   function automatic ins_t st(input logic [31:0] a, input logic [31:0] d);
      ins_t i = '0;
      i.memWrite = 1'b1;
      i.alu      = a;
      i.rt       = d;
      return i;
   endfunction

   // Drive one instruction into instance k, hold it through any stall, check it.
   task automatic issue(input int k, input ins_t i, input int expStalls);
      logic [7:0]  a;
      logic [31:0] old;
      logic        expTaken;
      logic [31:0] expTgt;
      wb_t         e;
      int          stalls;
      a          = i.alu[7:0];
      old        = model[k][a];
      e.regWrite = i.regWrite;
      e.memToReg = i.memToReg;
      e.data     = old;
      e.alu      = i.alu;
      e.rd       = i.rd;
      e.chkData  = i.memRead;
      sb.push_back(e);
      expTaken = i.jump | i.jumpMem | (i.brZero & i.zero) | (i.brNeg & i.neg);
      expTgt   = i.jumpMem ? old : (i.jump ? i.src1 : i.alu);
      if (i.memWrite) model[k][a] = i.rt;

      ins[k] = i;
      #1;
      stalls = 0;
      while (stallO[k] === 1'b1 && stalls < 16) begin
         vectors++;
         if (pcSrcO[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL pcSrc_in_stall lat%0d: got %b expected 0", k + 1, pcSrcO[k]);
         end
         stalls++;
         @(posedge clk);
         #1;
         vectors++;
         if (rwO[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL bubble lat%0d: regWriteWB got %b expected 0", k + 1, rwO[k]);
         end
      end
      vectors++;
      if (stalls !== expStalls) begin
         miscompares++;
         $display("FAIL stall_cycles lat%0d: got %0d expected %0d", k + 1, stalls, expStalls);
      end
      vectors++;
      if ({pcSrcO[k], flushO[k]} !== {expTaken, expTaken}) begin
         miscompares++;
         $display("FAIL pcSrc_flush lat%0d: got %b%b expected %b%b", k + 1,
                  pcSrcO[k], flushO[k], expTaken, expTaken);
      end
      if (expTaken) begin
         vectors++;
         if (tgtO[k] !== expTgt) begin
            miscompares++;
            $display("FAIL pcTarget lat%0d: got %h expected %h", k + 1, tgtO[k], expTgt);
         end
      end
      @(posedge clk);
      #1;
      ins[k] = '0;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty lat%0d: got 0 entries expected 1", k + 1);
      end else begin
         e = sb.pop_front();
         if ({rwO[k], mtrO[k], aluO[k], rdO[k]} !== {e.regWrite, e.memToReg, e.alu, e.rd}) begin
            miscompares++;
            $display("FAIL wb_regs lat%0d: got rw=%b mtr=%b alu=%h rd=%0d expected rw=%b mtr=%b alu=%h rd=%0d",
                     k + 1, rwO[k], mtrO[k], aluO[k], rdO[k], e.regWrite, e.memToReg, e.alu, e.rd);
         end
         if (e.chkData) begin
            vectors++;
            if (dataO[k] !== e.data) begin
               miscompares++;
               $display("FAIL memDataWB lat%0d: got %h expected %h", k + 1, dataO[k], e.data);
            end
         end
      end
   endtask

   task automatic checkZero(input int k, input string tag);
      vectors++;
      if ({stallO[k], pcSrcO[k], flushO[k], rwO[k], mtrO[k], dataO[k], aluO[k], rdO[k],
           lcO[k], scO[k], tcO[k]} !== '0) begin
         miscompares++;
         $display("FAIL %s lat%0d: got stall=%b pcSrc=%b rw=%b data=%h alu=%h rd=%0d cnt=%0d/%0d/%0d expected all 0",
                  tag, k + 1, stallO[k], pcSrcO[k], rwO[k], dataO[k], aluO[k], rdO[k], lcO[k], scO[k], tcO[k]);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) ins[k] = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) checkZero(k, "reset_state");
   endtask

   task automatic test_load_store();
      issue(0, st(32'd4, 32'hDEADBEEF), 0);
      issue(0, ld(32'd4, 6'd5), 0);
      issue(0, st(32'd9, 32'h1234_5678), 0);
      issue(0, ld(32'd9, 6'd63), 0);
   endtask

   task automatic test_load_stall();
      issue(2, st(32'd4, 32'hDEADBEEF), 2);
      issue(2, ld(32'd4, 6'd7), 2);
   endtask

   task automatic test_branch();
      ins_t i;
      i = '0; i.brZero = 1'b1; i.zero = 1'b1; i.alu = 32'h40;
      issue(0, i, 0);
      i.zero = 1'b0;
      issue(0, i, 0);
      i = '0; i.brNeg = 1'b1; i.neg = 1'b1; i.alu = 32'h88; i.regWrite = 1'b1; i.rd = 6'd3;
      issue(0, i, 0);
      i = '0; i.jump = 1'b1; i.src1 = 32'hCAFE_0000; i.alu = 32'h44;
      issue(0, i, 0);
   endtask

   task automatic test_jump_mem();
      ins_t i;
      issue(1, st(32'd8, 32'h100), 1);
      i = '0; i.jumpMem = 1'b1; i.jump = 1'b1; i.src1 = 32'h999; i.alu = 32'd8;
      issue(1, i, 1);
   endtask

   task automatic test_back_to_back();
      ins_t i;
      i = ld(32'd4, 6'd12);
      i.memWrite = 1'b1;
      i.rt       = 32'h0BAD_F00D;
      issue(0, i, 0);
      issue(0, ld(32'd4, 6'd13), 0);
      issue(2, st(32'd20, 32'h2020), 2);
      issue(2, ld(32'd20, 6'd14), 2);
      issue(2, ld(32'd4, 6'd15), 2);
   endtask

   task automatic test_reset_mid_wait();
      issue(2, st(32'd2, 32'h11), 2);
      ins[2] = st(32'd2, 32'h55);
      #1;
      vectors++;
      if (stallO[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL rstwait_stall: got %b expected 1", stallO[2]);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      ins[2] = '0;
      checkZero(2, "rst_mid_wait");
      issue(2, ld(32'd2, 6'd9), 2);
   endtask

   task automatic test_stats();
      ins_t  i;
      logic [31:0] expL;
      logic [31:0] expS;
      logic [31:0] expT;
      issue(0, st(32'h104, 32'hA5A5), 0);
      issue(0, st(32'h10, 32'h77), 0);
      issue(0, ld(32'd4, 6'd1), 0);
      issue(0, ld(32'h10, 6'd2), 0);
      issue(0, ld(32'h104, 6'd3), 0);
      i = '0; i.brNeg = 1'b1; i.neg = 1'b1; i.alu = 32'h80;
      issue(0, i, 0);
      i = '0; i.brZero = 1'b1; i.zero = 1'b0; i.alu = 32'h90;
      issue(0, i, 0);
`ifdef MEM_STATS_EN
      expL = 32'd3; expS = 32'd2; expT = 32'd1;
`else
      expL = 32'd0; expS = 32'd0; expT = 32'd0;
`endif
      vectors++;
      if ({lcO[0], scO[0], tcO[0]} !== {expL, expS, expT}) begin
         miscompares++;
         $display("FAIL counters: got %0d/%0d/%0d expected %0d/%0d/%0d",
                  lcO[0], scO[0], tcO[0], expL, expS, expT);
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) ins[k] = '0;
      test_reset();
      test_load_store();
      test_load_stall();
      test_branch();
      test_jump_mem();
      test_back_to_back();
      test_reset_mid_wait();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
